expr_tx: RTL

EXPR_TX -- requirements
Module: expr_tx

---
 rtl/expr_tx_pkg.sv | 46 ++++
 rtl/expr_tx_if.sv | 21 ++
 rtl/expr_fifo.sv | 60 ++++++
 rtl/expr_tx.sv | 138 +++++++++++++
 4 files changed

// File: rtl/expr_tx_pkg.sv
// Shared definitions for the expression transmitter: FSM state encodings,
// ASCII character constants and the term-buffer entry layout.
// Optional feature macro: EXPR_TX_TERM_EN adds the TERM state, which sends '='.
package expr_tx_pkg;

  // Width of one buffered term: {digit[3:0], op, last}.
  localparam int ENTRY_W = 6;

  localparam logic [7:0] ASCII_ZERO = 8'h30;  // '0'
  localparam logic [7:0] ASCII_PLUS = 8'h2B;  // '+'
  localparam logic [7:0] ASCII_STAR = 8'h2A;  // '*'
  localparam logic [7:0] ASCII_EQ   = 8'h3D;  // '='

`ifdef EXPR_TX_TERM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIG  = 2'd1,
    ST_OP   = 2'd2,
    ST_TERM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIG  = 2'd1,
    ST_OP   = 2'd2
  } state_t;
`endif

  // One operand plus the operator that follows it.
  typedef struct packed {
    logic [3:0] digit;
    logic       op;     // 0 = '+', 1 = '*'
    logic       last;   // final operand of the expression
  } term_t;

  // ASCII character for a decimal digit.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

  // ASCII character for an operator bit.
  function automatic logic [7:0] op_char(input logic op);
    return op ? ASCII_STAR : ASCII_PLUS;
  endfunction

endpackage

// File: rtl/expr_tx_if.sv
// Character stream interface: valid/ready handshake carrying one ASCII byte.
// The transmitter is the master, the downstream consumer is the slave.
interface expr_tx_if;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/expr_fifo.sv
// Term buffer for the expression transmitter: DEPTH-entry FIFO of term_t.
// A write while full is dropped even if a read happens in the same cycle;
// pointers wrap naturally because DEPTH is a power of two.
module expr_fifo
  import expr_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  wr_en,
  input  term_t wr_data,
  input  logic  rd_en,
  output term_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               wr_ok;
  logic               rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = term_t'(mem[rd_ptr]);

  // Storage write port.
  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/expr_tx.sv
// Expression transmitter: buffers {digit, op, last} terms and, on start,
// streams them as ASCII "d op d op ... d" over a valid/ready byte interface.
// Optional feature macro: EXPR_TX_TERM_EN appends '=' after the last digit,
// and done then follows the '=' transfer instead of the last digit.
module expr_tx
  import expr_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push,
  input  logic [3:0] digit,
  input  logic       op,
  input  logic       last,
  input  logic       start,
  expr_tx_if.master  tx,
  output logic       done,
  output logic       full,
  output logic       empty,
  output logic       err
);

  state_t     state;
  logic       valid_q;
  logic [7:0] data_q;
  logic       done_q;
  logic       err_q;

  term_t      wr_term;
  term_t      head;
  logic       digit_ok;
  logic       wr_en;
  logic       pop;

  assign digit_ok = (digit <= 4'd9);
  assign wr_en    = push && digit_ok;
  assign wr_term  = '{digit: digit, op: op, last: last};

  // An entry leaves the buffer when its digit character is accepted.
  assign pop = (state == ST_DIG) && valid_q && tx.tx_ready;

  expr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (wr_term),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign tx.tx_valid = valid_q;
  assign tx.tx_data  = data_q;
  assign done        = done_q;
  assign err         = err_q;

  // Transmit FSM with registered valid/data/done; the operator character is
  // captured into data_q when its digit is popped, so later pushes cannot
  // change it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_DIG;
            valid_q <= !empty;
            if (!empty) data_q <= digit_char(head.digit);
          end
        end

        ST_DIG: begin
          if (!valid_q) begin
            // Waiting for the next operand to arrive in the buffer.
            if (!empty) begin
              valid_q <= 1'b1;
              data_q  <= digit_char(head.digit);
            end
          end else if (tx.tx_ready) begin
            if (head.last) begin
`ifdef EXPR_TX_TERM_EN
              state  <= ST_TERM;
              data_q <= ASCII_EQ;
`else
              state   <= ST_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              state  <= ST_OP;
              data_q <= op_char(head.op);
            end
          end
        end

        ST_OP: begin
          if (tx.tx_ready) begin
            state   <= ST_DIG;
            valid_q <= !empty;
            if (!empty) data_q <= digit_char(head.digit);
          end
        end

`ifdef EXPR_TX_TERM_EN
        ST_TERM: begin
          if (tx.tx_ready) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif

        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: an out-of-range digit or a push into a full buffer.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      err_q <= 1'b0;
    end else if (push && (!digit_ok || full)) begin
      err_q <= 1'b1;
    end
  end

endmodule
